// File: rtl/neokeon_round_ctrl_if.sv
// Block interface for the Noekeon round controller: input block handshake,
// result handshake and the busy status flag.
interface neokeon_round_ctrl_if;
  logic         inValid;
  logic         inReady;
  logic         inDecrypt;
  logic [127:0] inDataState;
  logic [127:0] inDataKey;
  logic         outValid;
  logic         outReady;
  logic [127:0] outDataState;
  logic         busy;

  modport master (
    output inValid, inDecrypt, inDataState, inDataKey, outReady,
    input  inReady, outValid, outDataState, busy
  );

  modport slave (
    input  inValid, inDecrypt, inDataState, inDataKey, outReady,
    output inReady, outValid, outDataState, busy
  );
endinterface

// File: rtl/neokeon_round_ctrl.sv
// Iterative Noekeon encrypt/decrypt controller: one round per cycle, round
// constants generated on the fly, final Theta transform, result handshake.
//
// state | meaning
// IDLE  | waiting for a block, inReady high
// ROUND | one full round per cycle, rc stepped each round
// FINAL | output transform, result registered
// OUT   | result presented until outReady
module neokeon_round_ctrl #(
  parameter int         NUM_ROUNDS = 16,
  parameter logic [7:0] RC_FIRST   = 8'h80,
  parameter logic [7:0] RC_LAST    = 8'hD4
) (
  input logic                 clk,
  input logic                 rst,
  neokeon_round_ctrl_if.slave bus
);

  localparam int CntW = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, OUT} stateT;

  stateT           fsm;
  logic [127:0]    blockQ;
  logic [127:0]    keyQ;
  logic [127:0]    outQ;
  logic            decQ;
  logic            inReadyQ;
  logic            outValidQ;
  logic            busyQ;
  logic [CntW-1:0] roundCnt;
  logic [7:0]      rcQ;
  logic [31:0]     c1;
  logic [31:0]     c2;
  logic [127:0]    roundNext;
  logic [127:0]    finalNext;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Constants only ever touch word0 (bits 127:96).
  function automatic logic [127:0] stateXorConstant(input logic [127:0] s, input logic [31:0] c);
    return {s[127:96] ^ c, s[95:0]};
  endfunction

  function automatic logic [127:0] thetaFun(input logic [127:0] k, input logic [127:0] s);
    logic [31:0] a0, a1, a2, a3, t;
    {a0, a1, a2, a3} = s;
    t  = a0 ^ a2;
    t  = t ^ rotl(t, 8) ^ rotl(t, 24);
    a1 = a1 ^ t;
    a3 = a3 ^ t;
    a0 = a0 ^ k[127:96];
    a1 = a1 ^ k[95:64];
    a2 = a2 ^ k[63:32];
    a3 = a3 ^ k[31:0];
    t  = a1 ^ a3;
    t  = t ^ rotl(t, 8) ^ rotl(t, 24);
    a0 = a0 ^ t;
    a2 = a2 ^ t;
    return {a0, a1, a2, a3};
  endfunction

  function automatic logic [127:0] pi1Fun(input logic [127:0] s);
    return {s[127:96], rotl(s[95:64], 1), rotl(s[63:32], 5), rotl(s[31:0], 2)};
  endfunction

  function automatic logic [127:0] pi2Fun(input logic [127:0] s);
    return {s[127:96], rotl(s[95:64], 31), rotl(s[63:32], 27), rotl(s[31:0], 30)};
  endfunction

  function automatic logic [127:0] gammaFun(input logic [127:0] s);
    logic [31:0] a0, a1, a2, a3, t;
    {a0, a1, a2, a3} = s;
    a1 = a1 ^ (~a3 & ~a2);
    a0 = a0 ^ (a2 & a1);
    t  = a3;
    a3 = a0;
    a0 = t;
    a2 = a2 ^ a0 ^ a1 ^ a3;
    a1 = a1 ^ (~a3 & ~a2);
    a0 = a0 ^ (a2 & a1);
    return {a0, a1, a2, a3};
  endfunction

  function automatic logic [127:0] roundFun(input logic [127:0] k, input logic [127:0] s,
                                             input logic [31:0] k1, input logic [31:0] k2);
    return pi2Fun(gammaFun(pi1Fun(stateXorConstant(thetaFun(k, stateXorConstant(s, k1)), k2))));
  endfunction

  function automatic logic [7:0] rcFwd(input logic [7:0] rc);
    return {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] rcInv(input logic [7:0] rc);
    return rc[0] ? (((rc ^ 8'h1B) >> 1) | 8'h80) : (rc >> 1);
  endfunction

  // Round and final-transform datapath; direction picks which xor carries rc.
  always_comb begin
    c1        = decQ ? 32'h0 : {24'h0, rcQ};
    c2        = decQ ? {24'h0, rcQ} : 32'h0;
    roundNext = roundFun(keyQ, blockQ, c1, c2);
    finalNext = decQ ? stateXorConstant(thetaFun(keyQ, blockQ), {24'h0, rcQ})
                     : thetaFun(keyQ, stateXorConstant(blockQ, {24'h0, rcQ}));
  end

  // Sequencer with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      inReadyQ  <= 1'b1;
      outValidQ <= 1'b0;
      busyQ     <= 1'b0;
      outQ      <= '0;
      roundCnt  <= '0;
      rcQ       <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (bus.inValid) begin
            blockQ   <= bus.inDataState;
            keyQ     <= bus.inDataKey;
            decQ     <= bus.inDecrypt;
            roundCnt <= '0;
            rcQ      <= bus.inDecrypt ? RC_LAST : RC_FIRST;
            inReadyQ <= 1'b0;
            busyQ    <= 1'b1;
            fsm      <= ROUND;
          end
        end
        ROUND: begin
          blockQ <= roundNext;
          rcQ    <= decQ ? rcInv(rcQ) : rcFwd(rcQ);
          if (roundCnt == LastCnt) begin
            fsm <= FINAL;
          end else begin
            roundCnt <= roundCnt + CntW'(1);
          end
        end
        FINAL: begin
          outQ      <= finalNext;
          outValidQ <= 1'b1;
          busyQ     <= 1'b0;
          fsm       <= OUT;
        end
        OUT: begin
          if (bus.outReady) begin
            outValidQ <= 1'b0;
            inReadyQ  <= 1'b1;
            fsm       <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign bus.inReady      = inReadyQ;
  assign bus.outValid     = outValidQ;
  assign bus.outDataState = outQ;
  assign bus.busy         = busyQ;

endmodule

// File: tb/tb_neokeon_round_ctrl.sv
// Self-checking bench: a block-level Noekeon model plus a cycle-latency model
// checked every negedge, with directed known-answer cases and random traffic.
module tb_neokeon_round_ctrl;

  localparam int NR = 16;

  typedef logic [0:3][31:0] blk_t;

  localparam logic [127:0] CT_ZERO = 128'hb1656851_699e29fa_24b70148_503d2dfc;
  localparam logic [127:0] CT_ONES = 128'h2a78421b_87c7d092_4f26113f_1d1349b2;
  localparam logic [127:0] ONES    = {128{1'b1}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  neokeon_round_ctrl_if bus();

  neokeon_round_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // ---------------- block-level reference model ----------------
  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [7:0] mRc(input int i);
    logic [7:0] rc = 8'h80;
    for (int j = 0; j < i; j++) rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1B : 8'h00);
    return rc;
  endfunction

  function automatic blk_t mTheta(input blk_t k, input blk_t a);
    logic [31:0] t;
    t = a[0] ^ a[2];
    t = t ^ rl(t, 8) ^ rl(t, 24);
    a[1] = a[1] ^ t;
    a[3] = a[3] ^ t;
    for (int i = 0; i < 4; i++) a[i] = a[i] ^ k[i];
    t = a[1] ^ a[3];
    t = t ^ rl(t, 8) ^ rl(t, 24);
    a[0] = a[0] ^ t;
    a[2] = a[2] ^ t;
    return a;
  endfunction

  function automatic blk_t mPi(input blk_t a, input bit inv);
    int sh;
    for (int i = 1; i < 4; i++) begin
      sh = (i == 1) ? 1 : (i == 2) ? 5 : 2;
      a[i] = inv ? rl(a[i], 32 - sh) : rl(a[i], sh);
    end
    return a;
  endfunction

  function automatic blk_t mGamma(input blk_t a);
    logic [31:0] t;
    a[1] = a[1] ^ (~a[3] & ~a[2]);
    a[0] = a[0] ^ (a[2] & a[1]);
    t = a[3]; a[3] = a[0]; a[0] = t;
    a[2] = a[2] ^ a[0] ^ a[1] ^ a[3];
    a[1] = a[1] ^ (~a[3] & ~a[2]);
    a[0] = a[0] ^ (a[2] & a[1]);
    return a;
  endfunction

  function automatic blk_t mRound(input blk_t k, input blk_t a, input logic [7:0] k1, input logic [7:0] k2);
    a[0] = a[0] ^ {24'h0, k1};
    a = mTheta(k, a);
    a[0] = a[0] ^ {24'h0, k2};
    return mPi(mGamma(mPi(a, 1'b0)), 1'b1);
  endfunction

  function automatic logic [127:0] mEncrypt(input logic [127:0] key, input logic [127:0] blk);
    blk_t a = blk;
    for (int i = 0; i < NR; i++) a = mRound(key, a, mRc(i), 8'h00);
    a[0] = a[0] ^ {24'h0, mRc(NR)};
    return mTheta(key, a);
  endfunction

  function automatic logic [127:0] mDecrypt(input logic [127:0] wkey, input logic [127:0] blk);
    blk_t a = blk;
    for (int i = NR; i > 0; i--) a = mRound(wkey, a, 8'h00, mRc(i));
    a = mTheta(wkey, a);
    a[0] = a[0] ^ {24'h0, mRc(0)};
    return a;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // ---------------- per-cycle latency/handshake model ----------------
  localparam int P_IDLE = 0, P_BUSY = 1, P_OUT = 2;
  int           phase = P_IDLE;
  int           cnt = 0;
  bit           txDec = 1'b0;
  bit           started = 1'b0;
  logic         expInReady = 1'b1, expBusy = 1'b0, expOutValid = 1'b0;
  logic [127:0] expOut = '0, pendRes = '0;

  initial begin
    int k;
    forever begin
      @(negedge clk);
      if (started) begin
        check("inReady", 128'(bus.inReady), 128'(expInReady));
        check("busy", 128'(bus.busy), 128'(expBusy));
        check("outValid", 128'(bus.outValid), 128'(expOutValid));
        check("outDataState", bus.outDataState, expOut);
        if (phase == P_BUSY) begin
          k = NR + 1 - cnt;
          check("rc", 128'(dut.rcQ), 128'(txDec ? mRc(NR - k) : mRc(k)));
        end
      end
      started = 1'b1;
      if (rst) begin
        phase = P_IDLE; expInReady = 1'b1; expBusy = 1'b0; expOutValid = 1'b0; expOut = '0;
      end else begin
        case (phase)
          P_IDLE: if (bus.inValid) begin
            pendRes = bus.inDecrypt ? mDecrypt(bus.inDataKey, bus.inDataState)
                                    : mEncrypt(bus.inDataKey, bus.inDataState);
            txDec = bus.inDecrypt;
            cnt = NR + 1;
            phase = P_BUSY; expInReady = 1'b0; expBusy = 1'b1;
          end
          P_BUSY: begin
            cnt--;
            if (cnt == 0) begin
              phase = P_OUT; expBusy = 1'b0; expOutValid = 1'b1; expOut = pendRes;
            end
          end
          default: if (bus.outReady) begin
            phase = P_IDLE; expOutValid = 1'b0; expInReady = 1'b1;
          end
        endcase
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic sendBlock(input bit dec, input logic [127:0] st, input logic [127:0] key);
    int n = 0;
    logic r;
    bus.inValid = 1'b1; bus.inDecrypt = dec; bus.inDataState = st; bus.inDataKey = key;
    while (1) begin
      @(negedge clk);
      r = bus.inReady;
      @(posedge clk); #1;
      if (r === 1'b1) break;
      n++;
      if (n > 200) begin timeoutFail("accept"); break; end
    end
    bus.inValid = 1'b0;
  endtask

  task automatic waitOut(input bit holdReady, input int stall, output logic [127:0] res,
                         output int lat, output int busyCnt);
    lat = 0; busyCnt = 0;
    bus.outReady = holdReady;
    while (1) begin
      @(negedge clk);
      if (bus.busy === 1'b1) busyCnt++;
      if (bus.outValid === 1'b1) break;
      lat++;
      if (lat > 200) begin timeoutFail("outValid"); break; end
    end
    res = bus.outDataState;
    if (!holdReady) begin
      repeat (stall + 1) @(posedge clk);
      #1 bus.outReady = 1'b1;
    end
    @(posedge clk); #1;
    bus.outReady = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] res, held, key, pt, ct;
    int lat, bc;
    bus.inValid = 1'b0; bus.inDecrypt = 1'b0; bus.inDataState = '0; bus.inDataKey = '0;
    bus.outReady = 1'b0;

    check("model enc zero", mEncrypt('0, '0), CT_ZERO);
    check("model enc ones", mEncrypt(ONES, ONES), CT_ONES);
    check("model dec zero", mDecrypt('0, CT_ZERO), 128'h0);
    check("model rc16", 128'(mRc(NR)), 128'hD4);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("inReady after reset", 128'(bus.inReady), 128'h1);
    check("rc after reset", 128'(dut.rcQ), 128'h0);
    @(posedge clk); #1;

    // known answer, encrypt zero, outReady held high
    sendBlock(1'b0, '0, '0);
    waitOut(1'b1, 0, res, lat, bc);
    check("enc zero result", res, CT_ZERO);
    check("enc zero latency", 128'(lat), 128'(NR + 1));
    check("enc zero busy cycles", 128'(bc), 128'(NR + 1));

    sendBlock(1'b0, ONES, ONES);
    waitOut(1'b0, 1, res, lat, bc);
    check("enc ones result", res, CT_ONES);

    sendBlock(1'b1, CT_ZERO, '0);
    waitOut(1'b0, 0, res, lat, bc);
    check("dec zero result", res, 128'h0);
    check("dec latency", 128'(lat), 128'(NR + 1));

    // backpressure: hold off 10 cycles, then a single outReady pulse
    pt = {$urandom, $urandom, $urandom, $urandom};
    key = {$urandom, $urandom, $urandom, $urandom};
    sendBlock(1'b0, pt, key);
    bus.outReady = 1'b0;
    lat = 0;
    while (bus.outValid !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
    if (lat >= 200) timeoutFail("backpressure outValid");
    held = bus.outDataState;
    check("backpressure result", held, mEncrypt(key, pt));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp outValid", 128'(bus.outValid), 128'h1);
      check("bp outDataState", bus.outDataState, held);
      check("bp inReady", 128'(bus.inReady), 128'h0);
    end
    @(posedge clk); #1 bus.outReady = 1'b1;
    @(posedge clk); #1 bus.outReady = 1'b0;
    @(negedge clk);
    check("bp inReady after pulse", 128'(bus.inReady), 128'h1);
    check("bp outValid after pulse", 128'(bus.outValid), 128'h0);
    @(posedge clk); #1;

    // reset in the middle of the rounds
    sendBlock(1'b0, '0, '0);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst inReady", 128'(bus.inReady), 128'h1);
    check("midrst busy", 128'(bus.busy), 128'h0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("midrst outValid", 128'(bus.outValid), 128'h0);
    end
    @(posedge clk); #1;
    sendBlock(1'b0, '0, '0);
    waitOut(1'b1, 0, res, lat, bc);
    check("post-reset result", res, CT_ZERO);
    check("post-reset latency", 128'(lat), 128'(NR + 1));

    // inputs churn after accept
    sendBlock(1'b0, '0, '0);
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      bus.inValid = 1'($urandom_range(0, 1));
      bus.inDecrypt = 1'($urandom_range(0, 1));
      bus.inDataState = {$urandom, $urandom, $urandom, $urandom};
      bus.inDataKey = {$urandom, $urandom, $urandom, $urandom};
    end
    bus.inValid = 1'b0;
    waitOut(1'b0, 2, res, lat, bc);
    check("perturbed result", res, CT_ZERO);

    // encrypt then decrypt with the derived working key
    for (int i = 0; i < 3; i++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      sendBlock(1'b0, pt, key);
      waitOut(1'b0, 0, ct, lat, bc);
      sendBlock(1'b1, ct, mTheta('0, key));
      waitOut(1'b1, 0, res, lat, bc);
      check("roundtrip", res, pt);
    end

    // random traffic
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      pt = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      sendBlock(1'($urandom_range(0, 1)), pt, key);
      waitOut(1'($urandom_range(0, 1)), $urandom_range(0, 3), res, lat, bc);
      check("random latency", 128'(lat), 128'(NR + 1));
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/neokeon_round_ctrl.md
Name: neokeon_round_ctrl

Overview:
Iterative Noekeon encrypt/decrypt engine controller. It accepts one 128-bit block plus working key over a valid/ready handshake. It runs NUM_ROUNDS single-cycle rounds, generating the round constants with an on-the-fly LFSR, then applies the final output transform and presents the result over a valid/ready handshake. It sits between the system-side block interface and the round datapath leaf functions (StateXorConstant, Thetafun, Pi1fun, Gammafun, Pi2fun), which it instantiates and sequences.

Parameters:
NUM_ROUNDS, 16, number of full rounds; counter width is clog2(NUM_ROUNDS).
RC_FIRST, 8'h80, round constant of round 0 (encrypt start value).
RC_LAST, 8'hD4, constant at index NUM_ROUNDS (encrypt final transform / decrypt start value).

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous, active-high reset.
inValid  in  1  input block valid.
inReady  out  1  block can be accepted (high only in IDLE).
inDecrypt  in  1  0 = encrypt, 1 = decrypt; sampled on accept.
inDataState  in  128  plaintext/ciphertext; word0 in [127:96].
inDataKey  in  128  working key for the chosen direction (decrypt: caller supplies Theta(0,K)); sampled on accept.
outValid  out  1  result valid.
outReady  in  1  downstream accepts result.
outDataState  out  128  result block.
busy  out  1  high in ROUND or FINAL.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst has priority over everything: state goes to IDLE, and outValid, busy, outDataState, the round counter and the rc register all clear to 0. inReady is 1 the cycle after rst deasserts.
  - rst asserted mid-operation discards the block in flight; no partial result is ever presented.
- FSM states: IDLE, ROUND, FINAL, OUT.
- IDLE:
  - inReady = 1.
  - On inValid, register state, key and direction, clear the round counter, and go to ROUND.
  - rc loads RC_FIRST (encrypt) or RC_LAST (decrypt).
- ROUND:
  - Each cycle: state <= Round(state, key, c1, c2).
  - Round order: xor c1, Theta(key), xor c2, Pi1, Gamma, Pi2.
  - The c2 xor is live in the datapath, never tied off.
  - Encrypt: c1 = {24'h0, rc}, c2 = 0. Decrypt: c1 = 0, c2 = {24'h0, rc}.
  - Constant xor applies to the word defined by StateXorConstant.
  - rc steps every round:
    - Encrypt (forward): rc <= {rc[6:0],1'b0} ^ (rc[7] ? 8'h1B : 0).
    - Decrypt (inverse): rc <= rc[0] ? ((rc ^ 8'h1B) >> 1) | 8'h80 : rc >> 1.
  - Counter increments; after the round with counter == NUM_ROUNDS-1, go to FINAL.
  - At that point rc holds RC_LAST (encrypt) or RC_FIRST (decrypt) for default parameters.
- FINAL (one cycle):
  - Encrypt: outDataState <= Theta(key, state xor {24'h0, rc}).
  - Decrypt: outDataState <= Theta(key, state) xor {24'h0, rc}.
  - outValid <= 1; go to OUT.
- OUT:
  - outDataState is held stable while outValid && !outReady.
  - On outReady: outValid <= 0 next cycle, go to IDLE.
  - No overlap with a new accept: inReady stays 0 during OUT, including the handshake cycle.
- Latency:
  - Accept edge E0, rounds on edges E1..E16, outValid rises at E17 (NUM_ROUNDS+1 cycles).
  - Best-case issue interval is NUM_ROUNDS+3 cycles with outReady held high.
- Input changes: inDataState/inDataKey/inDecrypt changes after accept have no effect on the block in flight.
- Wrap-around: the round counter never wraps, because the FSM leaves ROUND at terminal count.

Test Plan:
- Encrypt, key 0, block 0: accept at E0 -> outValid at E17, outDataState = 128'hb1656851_699e29fa_24b70148_503d2dfc; busy high for exactly 17 cycles.
- Encrypt, key all-ones, block all-ones -> 128'h2a78421b_87c7d092_4f26113f_1d1349b2.
- Decrypt, working key 0 (Theta(0,0) = 0), block b1656851_699e29fa_24b70148_503d2dfc -> outDataState = 128'h0; also probe the decrypt rc sequence D4, 6A, 35, ..., 1B, then 80 in FINAL.
- Backpressure: outReady held 0 for 10 cycles after outValid -> outValid and outDataState stable, inReady stays 0; outReady pulsed 1 -> IDLE and inReady = 1 next cycle.
- Reset mid-op: rst high at round 7 for 1 cycle -> outValid stays 0, IDLE next cycle; a fresh zero-vector encrypt then yields b1656851_... with correct latency.
- Input perturbation: change inDataKey/inDataState/inDecrypt every cycle after accept -> result still equals the first-vector ciphertext.
